// File: rtl/bus_pkt_dispatch_if.sv
// Beat stream interface between the bus input FIFO, the dispatcher and the decoder lanes.
// The slave modport is the dispatcher's view; the master modport is the bus/lane side.
interface bus_pkt_dispatch_if #(
  parameter int BUS    = 534,
  parameter int NUM_CH = 16
);
  logic [BUS-1:0]    bus_data;
  logic              bus_en;
  logic              bus_ready;
  logic [BUS-1:0]    ch_data;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_ready;

  modport slave (
    input  bus_data, bus_en, ch_ready,
    output bus_ready, ch_data, ch_en
  );

  modport master (
    output bus_data, bus_en, ch_ready,
    input  bus_ready, ch_data, ch_en
  );
endinterface

// File: rtl/bus_pkt_dispatch.sv
// Packet-atomic round-robin demux of bus beats onto NUM_CH decoder lanes.
// Define DISPATCH_SKIP_BUSY_EN to let an idle dispatcher skip lanes that are not ready.
//
// state | meaning
// IDLE  | no lane locked; lane register holds the candidate for the next packet
// BUSY  | packet in flight; lane register holds the locked lane, cnt counts accepted beats
module bus_pkt_dispatch #(
  parameter int BUS           = 534,
  parameter int NUM_CH        = 16,
  parameter int CH_W          = 4,
  parameter int BEATS_PER_PKT = 25,
  parameter int CNT_W         = 9
) (
  input  logic            clk_bus,
  input  logic            rst,
  bus_pkt_dispatch_if.slave io,
  output logic [CH_W-1:0] cur_ch,
  output logic            pkt_done,
  output logic            ovf_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CH_W-1:0]  LAST_LANE = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BEATS_PER_PKT - 1);

  state_t            state, state_n;
  logic [CH_W-1:0]   lane, lane_n;
  logic [CH_W-1:0]   last_ch, last_n;
  logic [CH_W-1:0]   cand_hold, cand_wrap;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              acc, last_beat;
  logic              bus_ready_n, pkt_done_n;
  logic [NUM_CH-1:0] ch_en_n;

  function automatic logic [CH_W-1:0] nxt(input logic [CH_W-1:0] x);
    return (x == LAST_LANE) ? '0 : x + CH_W'(1);
  endfunction

`ifdef DISPATCH_SKIP_BUSY_EN
  // First ready lane after x, cyclically; falls back to x+1 when none is ready.
  function automatic logic [CH_W-1:0] pick(input logic [CH_W-1:0] x,
                                           input logic [NUM_CH-1:0] rdy);
    logic [CH_W-1:0] c;
    logic [CH_W-1:0] r;
    logic            found;
    c     = nxt(x);
    r     = c;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rdy[c]) begin
        found = 1'b1;
        r     = c;
      end
      c = nxt(c);
    end
    return r;
  endfunction

  always_comb begin
    cand_hold = pick(last_ch, io.ch_ready);
    cand_wrap = pick(lane, io.ch_ready);
  end
`else
  always_comb begin
    cand_hold = nxt(last_ch);
    cand_wrap = nxt(lane);
  end
`endif

  assign acc       = io.bus_en && io.bus_ready;
  assign last_beat = (state == BUSY) && (cnt == CNT_LAST);
  assign cur_ch    = lane;

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lane    <= '0;
      last_ch <= LAST_LANE;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lane    <= lane_n;
      last_ch <= last_n;
    end
  end

  // The beat that completes a packet hands the lane register straight to the next candidate,
  // so the following packet can start on the very next cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lane_n  = lane;
    last_n  = last_ch;
    case (state)
      IDLE: begin
        if (acc) begin
          state_n = BUSY;
          cnt_n   = CNT_W'(1);
        end else begin
          lane_n = cand_hold;
        end
      end
      BUSY: begin
        if (acc) begin
          if (last_beat) begin
            state_n = IDLE;
            cnt_n   = '0;
            last_n  = lane;
            lane_n  = cand_wrap;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus_ready_n = io.ch_ready[lane_n];
    ch_en_n     = acc ? (NUM_CH'(1) << lane) : '0;
    pkt_done_n  = acc && last_beat;
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      io.bus_ready <= 1'b0;
      io.ch_en     <= '0;
      io.ch_data   <= '0;
      pkt_done     <= 1'b0;
      ovf_err      <= 1'b0;
    end else begin
      io.bus_ready <= bus_ready_n;
      io.ch_en     <= ch_en_n;
      pkt_done     <= pkt_done_n;
      ovf_err      <= ovf_err | (io.bus_en & ~io.bus_ready);
      if (acc) io.ch_data <= io.bus_data;
    end
  end

endmodule

// File: tb/tb_bus_pkt_dispatch.sv
// Directed bench for bus_pkt_dispatch: 3 lanes, 6-beat packets, table of packets plus stall/overrun/reset sequences.
module tb_bus_pkt_dispatch;
  localparam int BUS = 16, NUM_CH = 3, CH_W = 2, BPP = 6, CNT_W = 3;
`ifdef DISPATCH_SKIP_BUSY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int L3 = SKIP ? 0 : 2;
  localparam int L4 = SKIP ? 1 : 0;
  localparam int L6 = (L4 + 1) % NUM_CH;

  logic            clk_bus = 1'b0;
  logic            rst = 1'b1;
  logic [CH_W-1:0] cur_ch;
  logic            pkt_done, ovf_err;
  int              errors = 0;
  int              checks = 0;

  bus_pkt_dispatch_if #(.BUS(BUS), .NUM_CH(NUM_CH)) io ();

  bus_pkt_dispatch #(.BUS(BUS), .NUM_CH(NUM_CH), .CH_W(CH_W),
                     .BEATS_PER_PKT(BPP), .CNT_W(CNT_W)) dut (
    .clk_bus (clk_bus),
    .rst     (rst),
    .io      (io),
    .cur_ch  (cur_ch),
    .pkt_done(pkt_done),
    .ovf_err (ovf_err)
  );

  always #5 clk_bus = ~clk_bus;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] oh(input int l);
    return NUM_CH'(1) << l;
  endfunction

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input int lane, input logic done, input string nm);
    int w = 0;
    while (io.bus_ready !== 1'b1 && w < 100) begin
      io.bus_en = 1'b0;
      tick();
      w++;
    end
    if (w == 100) chk($sformatf("%s ready timeout", nm), 32'(io.bus_ready), 1);
    io.bus_data = d;
    io.bus_en   = 1'b1;
    tick();
    io.bus_en   = 1'b0;
    chk($sformatf("%s ch_en d=%0h", nm, d), 32'(io.ch_en), 32'(oh(lane)));
    chk($sformatf("%s ch_data d=%0h", nm, d), 32'(io.ch_data), 32'(d));
    chk($sformatf("%s pkt_done d=%0h", nm, d), 32'(pkt_done), 32'(done));
  endtask

  task automatic send_pkt(input int lane, input logic [15:0] base, input string nm);
    chk($sformatf("%s cur_ch", nm), 32'(cur_ch), 32'(lane));
    for (int b = 0; b < BPP; b++) send_beat(base + 16'(b), lane, b == BPP - 1, nm);
  endtask

  typedef struct {
    logic [NUM_CH-1:0] rdy;
    int                lane;
    logic [15:0]       base;
  } vec_t;

  vec_t tbl[5];
  int   hi;
  logic [NUM_CH-1:0] seen;

  initial begin
    tbl[0] = '{rdy: 3'b111, lane: 0, base: 16'h0100};
    tbl[1] = '{rdy: 3'b111, lane: 1, base: 16'h0200};
    tbl[2] = '{rdy: 3'b111, lane: 2, base: 16'h0300};
    tbl[3] = '{rdy: 3'b111, lane: 0, base: 16'h0400};
    tbl[4] = '{rdy: 3'b111, lane: 1, base: 16'h0500};

    io.bus_en   = 1'b0;
    io.bus_data = '0;
    io.ch_ready = '1;
    tick();
    tick();
    chk("reset bus_ready", 32'(io.bus_ready), 0);
    chk("reset ch_en", 32'(io.ch_en), 0);
    chk("reset ch_data", 32'(io.ch_data), 0);
    chk("reset pkt_done", 32'(pkt_done), 0);
    chk("reset ovf_err", 32'(ovf_err), 0);
    chk("reset cur_ch", 32'(cur_ch), 0);

    // Overrun: bus_ready is still low in the first cycle after reset release.
    rst         = 1'b0;
    io.bus_data = 16'hdead;
    io.bus_en   = 1'b1;
    tick();
    io.bus_en   = 1'b0;
    chk("ovf set", 32'(ovf_err), 1);
    chk("ovf beat dropped ch_en", 32'(io.ch_en), 0);
    chk("ovf beat dropped ch_data", 32'(io.ch_data), 0);
    chk("ready after reset", 32'(io.bus_ready), 1);

    for (int k = 0; k < 5; k++) begin
      io.ch_ready = tbl[k].rdy;
      send_pkt(tbl[k].lane, tbl[k].base, $sformatf("pkt%0d", k));
    end

    // Next candidate lane 2 not ready for 40 cycles.
    io.ch_ready = 3'b011;
    tick();
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      hi += int'(io.bus_ready);
      tick();
    end
    chk("t3 ready cycles during stall", 32'(hi), SKIP ? 40 : 0);
    chk("t3 cur_ch during stall", 32'(cur_ch), 32'(L3));
    io.ch_ready = '1;
    send_pkt(L3, 16'h0600, "t3");
    chk("ovf sticky", 32'(ovf_err), 1);

    // Locked lane drops ready mid-packet: one more beat lands, then the bus stalls.
    chk("t4 cur_ch", 32'(cur_ch), 32'(L4));
    for (int b = 0; b < 3; b++) send_beat(16'h0700 + 16'(b), L4, 1'b0, "t4");
    io.ch_ready[L4] = 1'b0;
    send_beat(16'h0703, L4, 1'b0, "t4 late");
    chk("t4 ready dropped", 32'(io.bus_ready), 0);
    hi   = 0;
    seen = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      hi  += int'(io.bus_ready);
      seen |= io.ch_en;
    end
    chk("t4 stall ready cycles", 32'(hi), 0);
    chk("t4 stall ch_en", 32'(seen), 0);
    chk("t4 ch_data hold", 32'(io.ch_data), 32'h0703);
    io.ch_ready = '1;
    send_beat(16'h0704, L4, 1'b0, "t4");
    send_beat(16'h0705, L4, 1'b1, "t4");

    // Async reset in the middle of a packet.
    chk("t6 cur_ch", 32'(cur_ch), 32'(L6));
    for (int b = 0; b < 3; b++) send_beat(16'h0800 + 16'(b), L6, 1'b0, "t6");
    #2;
    rst = 1'b1;
    #1;
    chk("t6 async ch_en", 32'(io.ch_en), 0);
    chk("t6 async ch_data", 32'(io.ch_data), 0);
    chk("t6 async bus_ready", 32'(io.bus_ready), 0);
    chk("t6 async ovf_err", 32'(ovf_err), 0);
    chk("t6 async cur_ch", 32'(cur_ch), 0);
    chk("t6 async pkt_done", 32'(pkt_done), 0);
    tick();
    rst = 1'b0;
    send_pkt(0, 16'h0900, "t6 after");
    chk("t6 ovf clear", 32'(ovf_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
